// File: rtl/uart_tx_engine_pkg.sv
// uart_pkg: shared definitions for the UART transmit engine.
//   - state_t   : FSM state encoding (BREAK exists only when UART_TX_BREAK_EN
//                 is defined).
//   - PARITY_*  : values accepted by the PARITY_MODE parameter.
//   - frame_bits: number of serial bit periods in one frame.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    ,
    BREAK  = 3'd5
`endif
  } state_t;

  // Start bit + payload + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity_mode,
                                    input int stop_bits);
    return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// uart_tx_if: parallel-word handshake into the UART transmit engine.
//   tx_data  : payload word (DATA_BITS wide)
//   tx_valid : source has a word to send
//   tx_ready : engine can take a word this cycle
// Modports: master = frame source, slave = transmit engine.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_engine_baud_tick.sv
// uart_baud_tick: bit-period timer for the UART transmitter.
//   clk, rst : clock, synchronous active-low reset
//   restart  : force the count back to 0 (start of a new bit period)
//   en       : count while high
//   tick     : high in the last cycle of each CLKS_PER_BIT-cycle period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic en,
  output logic tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (restart) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

  assign tick = en && !restart && (count_reg == LAST);
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: parametrised UART transmitter (start, LSB-first data,
// optional parity, 1 or 2 stop bits).
// Ports:
//   clk, rst  : clock, synchronous active-low reset
//   tx_if     : uart_tx_if.slave (tx_data, tx_valid, tx_ready)
//   break_req : request a line break (only when UART_TX_BREAK_EN is defined)
//   txd       : registered serial output, idle high
//   busy      : a frame is in flight
//   done      : one-cycle pulse in the cycle the frame returns to IDLE
// Optional feature macro: UART_TX_BREAK_EN (adds break_req and the BREAK
// state: txd low while break_req is held, then 2 bit periods of mark).
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   tx_if,
`ifdef UART_TX_BREAK_EN
  input  logic       break_req,
`endif
  output logic       txd,
  output logic       busy,
  output logic       done
);
  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  state_t                 state_reg, state_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic                   parity_reg, parity_next;
  logic                   txd_reg, txd_next;
  logic                   done_reg, done_next;
  logic                   tick;
  logic                   accept;
  logic                   baud_restart;
  logic                   baud_en;

  assign tx_if.tx_ready = (state_reg == IDLE);
  assign accept         = (state_reg == IDLE) && tx_if.tx_valid;

`ifdef UART_TX_BREAK_EN
  // While the break is held the timer stays parked at 0 so the mark period
  // starts cleanly on release (bit_cnt 0 = holding, 1/2 = mark periods).
  logic brk_hold;
  assign brk_hold     = (state_reg == BREAK) && (bit_cnt_reg == '0);
  assign baud_restart = accept || brk_hold;
`else
  assign baud_restart = accept;
`endif
  assign baud_en = (state_reg != IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(baud_restart),
    .en     (baud_en),
    .tick   (tick)
  );

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    parity_next  = parity_reg;
    done_next    = 1'b0;
    txd_next     = 1'b1;

    case (state_reg)
      IDLE: begin
        if (tx_if.tx_valid) begin
          state_next   = START;
          shift_next   = tx_if.tx_data;
          bit_cnt_next = '0;
          // Odd parity is the inverse of the XOR of the payload.
          parity_next  = (^tx_if.tx_data) ^ (PARITY_MODE == PARITY_ODD);
        end
`ifdef UART_TX_BREAK_EN
        else if (break_req) begin
          state_next   = BREAK;
          bit_cnt_next = '0;
        end
`endif
      end
      START: begin
        if (tick) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == LAST_DATA) begin
            state_next   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_next   = STOP;
          bit_cnt_next = '0;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt_reg == LAST_STOP) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            done_next    = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        if (bit_cnt_reg == '0) begin
          if (!break_req) bit_cnt_next = CNT_W'(1);
        end else if (tick) begin
          if (bit_cnt_reg == CNT_W'(1)) begin
            bit_cnt_next = CNT_W'(2);
          end else begin
            state_next   = IDLE;
            bit_cnt_next = '0;
          end
        end
      end
`endif
      default: state_next = IDLE;
    endcase

    // txd is decoded from the upcoming state so the registered line
    // changes in the same cycle as the state it belongs to.
    case (state_next)
      START:  txd_next = 1'b0;
      DATA:   txd_next = shift_next[0];
      PARITY: txd_next = parity_next;
`ifdef UART_TX_BREAK_EN
      BREAK:  txd_next = (bit_cnt_next != '0);
`endif
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      parity_reg  <= 1'b0;
      txd_reg     <= 1'b1;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      parity_reg  <= parity_next;
      txd_reg     <= txd_next;
      done_reg    <= done_next;
    end
  end

  assign txd  = txd_reg;
  assign done = done_reg;
  assign busy = (state_reg == START) || (state_reg == DATA) ||
                (state_reg == PARITY) || (state_reg == STOP);
endmodule

// File: tb/tb_uart_tx_engine.sv
// Testbench for uart_tx_engine: five instances with CLKS_PER_BIT=4
// (8N1, 8E1, 8O1, 8N2, 5O2). Expected frames are built as bit lists from
// the payload and compared against txd cycle by cycle.
module tb_uart_tx_engine;
  localparam int C = 4;
  localparam int N = 5;
  localparam int DB_T [N] = '{8, 8, 8, 8, 5};
  localparam int PM_T [N] = '{0, 2, 1, 0, 1};
  localparam int SB_T [N] = '{1, 1, 1, 2, 2};

  logic         clk;
  logic         rst;
  logic [8:0]   data_w [N];
  logic [N-1:0] valid_w;
  logic [N-1:0] ready_w;
  logic [N-1:0] txd_w;
  logic [N-1:0] busy_w;
  logic [N-1:0] done_w;
  logic [N-1:0] brk_w;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    uart_tx_if #(.DATA_BITS(DB_T[gi])) ifs ();
    assign ifs.tx_data  = data_w[gi][DB_T[gi]-1:0];
    assign ifs.tx_valid = valid_w[gi];
    assign ready_w[gi]  = ifs.tx_ready;
    uart_tx_engine #(
      .CLKS_PER_BIT(C),
      .DATA_BITS   (DB_T[gi]),
      .PARITY_MODE (PM_T[gi]),
      .STOP_BITS   (SB_T[gi])
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .tx_if    (ifs),
`ifdef UART_TX_BREAK_EN
      .break_req(brk_w[gi]),
`endif
      .txd      (txd_w[gi]),
      .busy     (busy_w[gi]),
      .done     (done_w[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input int idx, input string tag, input logic t,
                              input logic b, input logic d, input logic r);
    check($sformatf("%s d%0d txd", tag, idx), 32'(txd_w[idx]), 32'(t));
    check($sformatf("%s d%0d busy", tag, idx), 32'(busy_w[idx]), 32'(b));
    check($sformatf("%s d%0d done", tag, idx), 32'(done_w[idx]), 32'(d));
    check($sformatf("%s d%0d ready", tag, idx), 32'(ready_w[idx]), 32'(r));
  endtask

  // Starts at a negedge; returns at the negedge of the done cycle (or just
  // after a reset pulse when abort_j >= 0).
  task automatic send(input int idx, input logic [8:0] d, input bit hold, input int abort_j);
    bit bits[$];
    int ones;
    int f;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DB_T[idx]; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (PM_T[idx] == 2) bits.push_back(ones % 2 == 1);
    else if (PM_T[idx] == 1) bits.push_back(ones % 2 == 0);
    for (int i = 0; i < SB_T[idx]; i++) bits.push_back(1'b1);
    f = bits.size() * C;

    data_w[idx]  = d;
    valid_w[idx] = 1'b1;
    check($sformatf("ready_at_offer d%0d", idx), 32'(ready_w[idx]), 32'd1);
    @(posedge clk);
    for (int j = 0; j < f; j++) begin
      @(negedge clk);
      if (j == 0 && !hold) valid_w[idx] = 1'b0;
      if (j == 6) begin
        data_w[idx]  = 9'($urandom);
        valid_w[idx] = 1'b1;
      end
      if (j == 8) valid_w[idx] = hold;
      check($sformatf("bit d%0d j=%0d", idx, j), 32'(txd_w[idx]), 32'(bits[j / C]));
      check($sformatf("busy d%0d j=%0d", idx, j), 32'(busy_w[idx]), 32'd1);
      check($sformatf("done d%0d j=%0d", idx, j), 32'(done_w[idx]), 32'd0);
      if (j == abort_j) begin
        rst          = 1'b0;
        valid_w[idx] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_status(idx, "abort", 1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        $display("tx dut=%0d data=%03h aborted at cycle %0d", idx, d, j);
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    check_status(idx, "end", 1'b1, 1'b0, 1'b1, 1'b1);
    $display("tx dut=%0d data=%03h frame_cycles=%0d", idx, d, f);
  endtask

  task automatic idle_check(input int idx, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_status(idx, "idle", 1'b1, 1'b0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    rst     = 1'b0;
    valid_w = '0;
    brk_w   = '0;
    for (int i = 0; i < N; i++) data_w[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) check_status(i, "in_reset", 1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) check_status(i, "after_reset", 1'b1, 1'b0, 1'b0, 1'b1);

    send(0, 9'h055, 1'b0, -1);   // 8N1, 40 cycles
    send(1, 9'h007, 1'b0, -1);   // even parity -> 1
    send(2, 9'h007, 1'b0, -1);   // odd parity  -> 0
    send(3, 9'h0A3, 1'b1, -1);   // back-to-back, 2 stop bits
    send(3, 9'h03C, 1'b0, -1);
    idle_check(3, 6);            // no third accept
    send(0, 9'h0B6, 1'b0, 13);   // reset inside the 3rd data bit
    idle_check(0, 8);
    send(0, 9'h0FF, 1'b0, -1);

    for (int idx = 0; idx < N; idx++) begin
      for (int k = 0; k < 4; k++) begin
        send(idx, 9'($urandom), (k < 3) ? 1'($urandom_range(0, 1)) : 1'b0, -1);
      end
      idle_check(idx, 2);
    end

`ifdef UART_TX_BREAK_EN
    brk_w[0] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("brk_low txd j=%0d", j), 32'(txd_w[0]), 32'd0);
      check($sformatf("brk_low ready j=%0d", j), 32'(ready_w[0]), 32'd0);
    end
    brk_w[0] = 1'b0;
    for (int j = 0; j < 2 * C; j++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("brk_mark txd j=%0d", j), 32'(txd_w[0]), 32'd1);
      check($sformatf("brk_mark ready j=%0d", j), 32'(ready_w[0]), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    check("brk_end ready", 32'(ready_w[0]), 32'd1);
    $display("break dut=0 low=20 mark=%0d", 2 * C);
    send(0, 9'h05A, 1'b0, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
